// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned WORD_LSB = 2;

    typedef enum logic [1:0] {
        S_ARB,
        S_LOCK,
        S_RELEASE
    } arb_state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_LD
    } owner_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    // Misaligned or beyond the last word of dmem.
    function automatic logic addr_err(input logic [XLEN-1:0] addr, input int unsigned mem_words);
        return (addr[WORD_LSB-1:0] != '0) ||
               (addr[XLEN-1:WORD_LSB] >= (XLEN-WORD_LSB)'(mem_words));
    endfunction

    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:WORD_LSB], WORD_LSB'(0)};
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic            core_req, core_we, core_gnt, core_stall, core_rvalid, core_err;
    logic [XLEN-1:0] core_addr, core_wdata, core_rdata;
    logic            ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid, ld_err;
    logic [XLEN-1:0] ld_addr, ld_wdata, ld_rdata;
    logic            mem_we;
    logic [XLEN-1:0] mem_a, mem_wd, mem_rd;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata, core_err,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_gnt, ld_rvalid, ld_rdata, ld_err,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata, core_err,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/dmem_arb_rsp.sv
// Registered read-data / error response for one requester, valid the cycle after its grant.
module dmem_arb_rsp
    import dmem_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            gnt_i,
    input  logic            we_i,
    input  logic            err_i,
    input  logic [XLEN-1:0] rd_i,
    output logic            rvalid_o,
    output logic            err_o,
    output logic [XLEN-1:0] rdata_o
);

    logic            rvalid_d, rvalid_q;
    logic            err_d, err_q;
    logic [XLEN-1:0] rdata_d, rdata_q;

    // Writes and faulting accesses return zero data.
    always_comb begin
        rvalid_d = gnt_i;
        err_d    = gnt_i & err_i;
        rdata_d  = (gnt_i & ~we_i & ~err_i) ? rd_i : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter between the core MEM stage and the loader, with starvation and lock limits.
// Optional grant/conflict statistics counters enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned LOCK_MAX  = 16,
    parameter int unsigned CW        = 5
) (
    input  logic          clk,
    input  logic          rst,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   stat_core_gnt,
    output logic [15:0]   stat_ld_gnt,
    output logic [15:0]   stat_conflict,
`endif
    dmem_arbiter_if.slave bus
);

    arb_state_e      state_d, state_q;
    logic [CW-1:0]   wait_d, wait_q;
    logic [CW-1:0]   lock_d, lock_q;
    logic            core_gnt_c, ld_gnt_c;
    logic            core_err_c, ld_err_c, sel_err_c;
    owner_e          own_c;
    mem_req_t        core_r, ld_r, sel_r;

    assign core_r     = {bus.core_we, bus.core_addr, bus.core_wdata};
    assign ld_r       = {bus.ld_we, bus.ld_addr, bus.ld_wdata};
    assign core_err_c = addr_err(bus.core_addr, MEM_WORDS);
    assign ld_err_c   = addr_err(bus.ld_addr, MEM_WORDS);

    // Grant selection and next-state for wait/lock bookkeeping.
    always_comb begin
        core_gnt_c = 1'b0;
        ld_gnt_c   = 1'b0;
        state_d    = state_q;
        wait_d     = wait_q;
        lock_d     = lock_q;
        unique case (state_q)
            S_ARB: begin
                if (bus.core_req && !(bus.ld_req && wait_q == CW'(MAX_WAIT))) begin
                    core_gnt_c = 1'b1;
                end else if (bus.ld_req) begin
                    ld_gnt_c = 1'b1;
                end
                if (ld_gnt_c || !bus.ld_req) begin
                    wait_d = '0;
                end else if (wait_q != CW'(MAX_WAIT)) begin
                    wait_d = wait_q + CW'(1);
                end
                if (ld_gnt_c && bus.ld_lock) begin
                    state_d = S_LOCK;
                    lock_d  = CW'(1);
                end
            end
            S_LOCK: begin
                wait_d = '0;
                if (bus.ld_req && bus.ld_lock) begin
                    ld_gnt_c = 1'b1;
                    lock_d   = lock_q + CW'(1);
                    if (lock_q == CW'(LOCK_MAX - 1)) begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    core_gnt_c = bus.core_req;
                    lock_d     = '0;
                    state_d    = S_ARB;
                end
            end
            S_RELEASE: begin
                core_gnt_c = bus.core_req;
                ld_gnt_c   = bus.ld_req & ~bus.core_req;
                wait_d     = '0;
                lock_d     = '0;
                state_d    = S_ARB;
            end
            default: begin
                wait_d  = '0;
                lock_d  = '0;
                state_d = S_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ARB;
            wait_q  <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lock_q  <= lock_d;
        end
    end

    // Core owns the memory port unless the loader holds the grant.
    assign own_c     = ld_gnt_c ? OWN_LD : OWN_CORE;
    assign sel_r     = (own_c == OWN_LD) ? ld_r : core_r;
    assign sel_err_c = (own_c == OWN_LD) ? ld_err_c : core_err_c;

    assign bus.mem_we     = rst & (core_gnt_c | ld_gnt_c) & sel_r.we & ~sel_err_c;
    assign bus.mem_a      = word_addr(sel_r.addr);
    assign bus.mem_wd     = sel_r.wdata;
    assign bus.core_gnt   = core_gnt_c;
    assign bus.ld_gnt     = ld_gnt_c;
    assign bus.core_stall = bus.core_req & ~core_gnt_c;

    dmem_arb_rsp u_core_rsp (
        .clk      (clk),
        .rst_n    (rst),
        .gnt_i    (core_gnt_c),
        .we_i     (bus.core_we),
        .err_i    (core_err_c),
        .rd_i     (bus.mem_rd),
        .rvalid_o (bus.core_rvalid),
        .err_o    (bus.core_err),
        .rdata_o  (bus.core_rdata)
    );

    dmem_arb_rsp u_ld_rsp (
        .clk      (clk),
        .rst_n    (rst),
        .gnt_i    (ld_gnt_c),
        .we_i     (bus.ld_we),
        .err_i    (ld_err_c),
        .rd_i     (bus.mem_rd),
        .rvalid_o (bus.ld_rvalid),
        .err_o    (bus.ld_err),
        .rdata_o  (bus.ld_rdata)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] st_cg_d, st_cg_q, st_lg_d, st_lg_q, st_cf_d, st_cf_q;

    // Saturating event counters.
    always_comb begin
        st_cg_d = st_cg_q;
        st_lg_d = st_lg_q;
        st_cf_d = st_cf_q;
        if (core_gnt_c && st_cg_q != 16'hFFFF) st_cg_d = st_cg_q + 16'd1;
        if (ld_gnt_c && st_lg_q != 16'hFFFF) st_lg_d = st_lg_q + 16'd1;
        if (bus.core_req && bus.ld_req && st_cf_q != 16'hFFFF) st_cf_d = st_cf_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_cg_q <= '0;
            st_lg_q <= '0;
            st_cf_q <= '0;
        end else begin
            st_cg_q <= st_cg_d;
            st_lg_q <= st_lg_d;
            st_cf_q <= st_cf_d;
        end
    end

    assign stat_core_gnt = st_cg_q;
    assign stat_ld_gnt   = st_lg_q;
    assign stat_conflict = st_cf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences, randomized model compare.
module tb_dmem_arbiter;

    localparam int unsigned MEM_WORDS = 64;
    localparam int unsigned MAX_WAIT  = 4;
    localparam int unsigned LOCK_MAX  = 16;
    localparam int          NV        = 10;
    localparam int          NRAND     = 3000;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   n_chk = 0;
    int   n_err = 0;

    dmem_arbiter_if bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] s_cg, s_lg, s_cf;
`endif

    dmem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
`ifdef DMEM_ARB_STATS_EN
        .stat_core_gnt (s_cg),
        .stat_ld_gnt   (s_lg),
        .stat_conflict (s_cf),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Behavioural dmem: combinational read, write on posedge.
    logic [31:0] dmem [MEM_WORDS];
    assign bus.mem_rd = (bus.mem_a[31:2] < 30'(MEM_WORDS)) ? dmem[bus.mem_a[7:2]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) dmem[i] <= 32'h0;
        end else if (bus.mem_we && bus.mem_a[31:2] < 30'(MEM_WORDS)) begin
            dmem[bus.mem_a[7:2]] <= bus.mem_wd;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          cr, cw;
        logic [31:0] ca, cd;
        bit          lr, lw;
        logic [31:0] la, ld;
        bit          e_cg, e_lg, e_we;
        logic [31:0] e_a;
        bit          e_err;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vec [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic drv(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld,
                       input bit ll);
        bus.core_req   = cr;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.ld_req     = lr;
        bus.ld_we      = lw;
        bus.ld_addr    = la;
        bus.ld_wdata   = ld;
        bus.ld_lock    = ll;
    endtask

    function automatic bit m_err(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= 32'(MEM_WORDS));
    endfunction

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return $urandom;
        if (r == 1) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        if (r == 2) return 32'($urandom_range(64, 80) * 4);
        return 32'($urandom_range(0, 63) * 4);
    endfunction

    // Reference model state: loader denial streak, length of current lock run, post-lock release slot.
    int          denied, lock_run;
    bit          after_lock;
    logic [31:0] shadow [MEM_WORDS];

    initial begin
        bit          pc, pl, cw, lw, ll, eg_c, eg_l, e_we;
        bit          e_crv, e_cerr, e_lrv, e_lerr;
        logic [31:0] ca, cd, la, ld, e_crd, e_lrd, e_a, e_wd;
        int          k;
        bit          ecg;

        vec[0] = '{1, 1, 32'h8,   32'hAA,   0, 0, 32'h0,   32'h0,    1, 0, 1, 32'h8,   0, 32'h0};
        vec[1] = '{1, 0, 32'h8,   32'h0,    0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h8,   0, 32'hAA};
        vec[2] = '{0, 0, 32'h0,   32'h0,    1, 1, 32'h100, 32'h77,   0, 1, 0, 32'h100, 1, 32'h0};
        vec[3] = '{1, 0, 32'h6,   32'h0,    0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h4,   1, 32'h0};
        vec[4] = '{1, 1, 32'h10,  32'h55,   1, 0, 32'h20,  32'h0,    1, 0, 1, 32'h10,  0, 32'h0};
        vec[5] = '{0, 0, 32'h1C,  32'h0,    0, 0, 32'h20,  32'h0,    0, 0, 0, 32'h1C,  0, 32'h0};
        vec[6] = '{0, 0, 32'h0,   32'h0,    1, 1, 32'hFC,  32'h1234, 0, 1, 1, 32'hFC,  0, 32'h0};
        vec[7] = '{0, 0, 32'h0,   32'h0,    1, 0, 32'hFC,  32'h0,    0, 1, 0, 32'hFC,  0, 32'h1234};
        vec[8] = '{1, 1, 32'h103, 32'h99,   0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h100, 1, 32'h0};
        vec[9] = '{1, 0, 32'h10,  32'h0,    0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h10,  0, 32'h55};

        // Reset with live write requests: no memory write, all responses cleared.
        rst = 1'b0;
        clr = 1'b1;
        drv(1, 1, 32'h8, 32'h1, 1, 1, 32'h10, 32'h2, 1);
        #2;
        chk1("reset mem_we", bus.mem_we, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk1("reset core_rvalid", bus.core_rvalid, 1'b0);
        chk1("reset core_err", bus.core_err, 1'b0);
        chk("reset core_rdata", bus.core_rdata, 32'h0);
        chk1("reset ld_rvalid", bus.ld_rvalid, 1'b0);
        chk1("reset ld_err", bus.ld_err, 1'b0);
        chk("reset ld_rdata", bus.ld_rdata, 32'h0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        clr = 1'b0;

`ifdef DMEM_ARB_STATS_EN
        chk("stat_conflict reset", 32'(s_cf), 32'd0);
        for (int c = 0; c < 10; c++) begin
            drv(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 0);
            @(posedge clk);
            #1;
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stat_conflict", 32'(s_cf), 32'd10);
        chk("stat_core_gnt", 32'(s_cg), 32'd8);
        chk("stat_ld_gnt", 32'(s_lg), 32'd2);
`endif

        // Single-cycle vector table.
        for (int i = 0; i < NV; i++) begin
            drv(vec[i].cr, vec[i].cw, vec[i].ca, vec[i].cd, vec[i].lr, vec[i].lw, vec[i].la, vec[i].ld, 0);
            #3;
            chk1($sformatf("v%0d core_gnt", i), bus.core_gnt, vec[i].e_cg);
            chk1($sformatf("v%0d ld_gnt", i), bus.ld_gnt, vec[i].e_lg);
            chk1($sformatf("v%0d mem_we", i), bus.mem_we, vec[i].e_we);
            chk($sformatf("v%0d mem_a", i), bus.mem_a, vec[i].e_a);
            @(posedge clk);
            #1;
            chk1($sformatf("v%0d core_rvalid", i), bus.core_rvalid, vec[i].e_cg);
            chk1($sformatf("v%0d ld_rvalid", i), bus.ld_rvalid, vec[i].e_lg);
            if (vec[i].e_cg) begin
                chk1($sformatf("v%0d core_err", i), bus.core_err, vec[i].e_err);
                chk($sformatf("v%0d core_rdata", i), bus.core_rdata, vec[i].e_rd);
            end
            if (vec[i].e_lg) begin
                chk1($sformatf("v%0d ld_err", i), bus.ld_err, vec[i].e_err);
                chk($sformatf("v%0d ld_rdata", i), bus.ld_rdata, vec[i].e_rd);
            end
        end

        // Starvation limit: loader forced through on the fifth conflicting cycle.
        for (int c = 0; c < 6; c++) begin
            drv(1, 0, 32'h8, 0, 1, 0, 32'hFC, 0, 0);
            #3;
            chk1($sformatf("starve c%0d core_gnt", c), bus.core_gnt, c != 4);
            chk1($sformatf("starve c%0d ld_gnt", c), bus.ld_gnt, c == 4);
            chk1($sformatf("starve c%0d core_stall", c), bus.core_stall, c == 4);
            @(posedge clk);
            #1;
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Locked loader burst against a waiting core.
        k = 0;
        for (int c = 0; c < 26; c++) begin
            ecg = (c < 4) || (c >= 20 && c <= 24);
            drv(1, 0, 32'h8, 0, 1, 1, 32'(k * 4), 32'(k + 100), 1);
            #3;
            chk1($sformatf("lock c%0d core_gnt", c), bus.core_gnt, ecg);
            chk1($sformatf("lock c%0d ld_gnt", c), bus.ld_gnt, !ecg);
            if (!ecg) k++;
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a lock.
        drv(1, 0, 32'h8, 0, 1, 1, 32'(k * 4), 32'hCAFE, 1);
        #3;
        chk1("lock pre-reset ld_gnt", bus.ld_gnt, 1'b1);
        chk1("lock pre-reset mem_we", bus.mem_we, 1'b1);
        rst = 1'b0;
        #1;
        chk1("mid-lock reset mem_we", bus.mem_we, 1'b0);
        @(posedge clk);
        #1;
        chk1("reset cycle core_rvalid", bus.core_rvalid, 1'b0);
        chk1("reset cycle ld_rvalid", bus.ld_rvalid, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk1("post-reset core_rvalid", bus.core_rvalid, 1'b0);
        chk1("post-reset ld_rvalid", bus.ld_rvalid, 1'b0);
        drv(1, 0, 32'h8, 0, 1, 0, 32'h4, 0, 1);
        #3;
        chk1("post-reset core_gnt", bus.core_gnt, 1'b1);
        chk1("post-reset ld_gnt", bus.ld_gnt, 1'b0);
        @(posedge clk);
        #1;
        chk1("post-reset core_rvalid after gnt", bus.core_rvalid, 1'b1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the reference model.
        rst = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < int'(MEM_WORDS); i++) shadow[i] = 32'h0;
        denied = 0;
        lock_run = 0;
        after_lock = 0;
        pc = 0; pl = 0; cw = 0; lw = 0; ll = 0;
        ca = 0; cd = 0; la = 0; ld = 0;

        for (int n = 0; n < NRAND; n++) begin
            if (!pc && $urandom_range(0, 9) < 7) begin
                pc = 1;
                cw = 1'($urandom_range(0, 1));
                ca = rnd_addr();
                cd = $urandom;
            end
            if (!pl && ($urandom_range(0, 9) < 4 || (lock_run > 0 && $urandom_range(0, 9) < 9))) begin
                pl = 1;
                lw = 1'($urandom_range(0, 1));
                la = rnd_addr();
                ld = $urandom;
                ll = (lock_run > 0) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3);
            end
            drv(pc, cw, ca, cd, pl, lw, la, ld, pl & ll);
            #3;

            eg_c = 0;
            eg_l = 0;
            if (lock_run > 0) begin
                if (pl && ll) begin
                    eg_l = 1;
                    lock_run++;
                    if (lock_run == int'(LOCK_MAX)) begin
                        lock_run = 0;
                        after_lock = 1;
                    end
                end else begin
                    eg_c = pc;
                    lock_run = 0;
                end
                denied = 0;
            end else if (after_lock) begin
                eg_c = pc;
                eg_l = pl && !pc;
                after_lock = 0;
                denied = 0;
            end else begin
                eg_l = pl && (!pc || denied == int'(MAX_WAIT));
                eg_c = pc && !eg_l;
                if (pl && !eg_l) denied = (denied < int'(MAX_WAIT)) ? denied + 1 : denied;
                else denied = 0;
                if (eg_l && ll) lock_run = 1;
            end

            e_we = (eg_c && cw && !m_err(ca)) || (eg_l && lw && !m_err(la));
            e_a  = eg_l ? (la / 4) * 4 : (ca / 4) * 4;
            e_wd = eg_l ? ld : cd;
            chk1("rand core_gnt", bus.core_gnt, eg_c);
            chk1("rand ld_gnt", bus.ld_gnt, eg_l);
            chk1("rand core_stall", bus.core_stall, pc && !eg_c);
            chk1("rand mem_we", bus.mem_we, e_we);
            chk("rand mem_a", bus.mem_a, e_a);
            if (e_we) chk("rand mem_wd", bus.mem_wd, e_wd);

            e_crv  = eg_c;
            e_cerr = eg_c && m_err(ca);
            e_crd  = (eg_c && !cw && !m_err(ca)) ? shadow[int'(ca / 4)] : 32'h0;
            e_lrv  = eg_l;
            e_lerr = eg_l && m_err(la);
            e_lrd  = (eg_l && !lw && !m_err(la)) ? shadow[int'(la / 4)] : 32'h0;
            if (e_we) shadow[int'(e_a / 4)] = e_wd;
            if (eg_c) pc = 0;
            if (eg_l) pl = 0;

            @(posedge clk);
            #1;
            chk1("rand core_rvalid", bus.core_rvalid, e_crv);
            chk1("rand ld_rvalid", bus.ld_rvalid, e_lrv);
            if (e_crv) begin
                chk1("rand core_err", bus.core_err, e_cerr);
                chk("rand core_rdata", bus.core_rdata, e_crd);
            end
            if (e_lrv) begin
                chk1("rand ld_err", bus.ld_err, e_lerr);
                chk("rand ld_rdata", bus.ld_rdata, e_lrd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline MEM stage (core) and a debug/program loader port (ld). It grants at most one word access per cycle, applies starvation and lock limits, and range/alignment-checks each access. Returned read data is registered, with valid one cycle after grant. The block sits between the MEM stage / loader and dmem. Its memory-side ports match dmem's clk/we/a/wd/rd interface.

Parameters:
MEM_WORDS, 64, number of 32-bit words in dmem; word index >= MEM_WORDS is out of range
MAX_WAIT, 4, consecutive cycles a pending loader request may be denied before it is forced through
LOCK_MAX, 16, maximum consecutive granted cycles in a loader lock before forced release
CW, 5, width of wait/lock counters (must hold max(MAX_WAIT, LOCK_MAX))

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous active-low reset
core_req  in  1  core access request
core_we  in  1  core write enable
core_addr  in  32  core byte address
core_wdata  in  32  core write data
core_gnt  out  1  core granted this cycle (combinational)
core_stall  out  1  core_req & ~core_gnt (to hazard unit)
core_rvalid  out  1  registered; pulses the cycle after a core grant
core_rdata  out  32  registered read data
core_err  out  1  registered; with rvalid, access was misaligned or out of range
ld_req, ld_we, ld_addr[31:0], ld_wdata[31:0], ld_lock  in  loader request, same meaning; ld_lock requests burst ownership
ld_gnt, ld_rvalid, ld_rdata[31:0], ld_err  out  loader equivalents of the core signals
mem_we  out  1  to dmem we
mem_a  out  32  to dmem a, always {addr[31:2],2'b00}
mem_wd  out  32  to dmem wd
mem_rd  in  32  from dmem rd (combinational read)

Behaviour:
- Reset (rst=0, async): state=S_ARB; wait_cnt=0; lock_cnt=0; all rvalid, err and rdata outputs = 0. mem_we is forced to 0 while rst=0.
- Combinational grant, one owner per cycle. Default owner is core, selecting mem_a/mem_wd when neither request is active.
- S_ARB:
  - core_req=1: core wins, unless ld_req=1 and wait_cnt==MAX_WAIT; then loader wins and core stalls.
  - core_req=0 and ld_req=1: loader wins.
  - wait_cnt increments while ld_req=1 and denied. It clears on any loader grant or when ld_req=0. It saturates at MAX_WAIT.
  - Loader grant with ld_lock=1: go to S_LOCK with lock_cnt=1.
- S_LOCK:
  - Loader owns memory; core_gnt=0.
  - ld_req=1 & ld_lock=1: grant loader, lock_cnt++.
  - ld_req=0 or ld_lock=0: no grant that cycle (core may be granted if core_req=1); go to S_ARB.
  - lock_cnt==LOCK_MAX while still locked: go to S_RELEASE.
- S_RELEASE:
  - One cycle; core has absolute priority. Loader is granted only if core_req=0.
  - Next state S_ARB; wait_cnt=0.
- Checks:
  - err_cond = addr[1:0]!=0 or addr[31:2]>=MEM_WORDS.
  - A granted access with err_cond never asserts mem_we. It still consumes the slot.
  - rvalid=1, err=1, rdata=0 next cycle.
- Read/write response:
  - On grant, mem_we = we & ~err_cond.
  - Next cycle: rvalid=1 for the owner, rdata = captured mem_rd (0 for writes), err = err_cond.
  - rvalid is a single-cycle pulse per grant; back-to-back grants give back-to-back pulses.
- Simultaneous: same-cycle core and loader requests never both receive gnt; the loser holds its request (req/addr/wdata must stay stable until gnt).
- Reset mid-lock or mid-wait: immediate return to S_ARB; no response pulse for an access granted in the reset cycle.

Optional Feature:
DMEM_ARB_STATS_EN:
- When defined, adds outputs stat_core_gnt[15:0], stat_ld_gnt[15:0] and stat_conflict[15:0].
- stat_conflict counts cycles with core_req & ld_req. All three counters saturate at 16'hFFFF and reset to 0.
- When not defined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg: state enum (S_ARB, S_LOCK, S_RELEASE), owner enum (OWN_CORE, OWN_LD), word-address helper constant WORD_LSB=2.
- One sub-module: dmem_arb_rsp, the registered response/err capture, instanced once per requester.

Test Plan:
- Core write 0x0000_00AA to addr 0x8, then read 0x8 -> core_gnt same cycle; core_rvalid next cycle with rdata=0x0000_00AA, err=0.
- core_req and ld_req held high for 6 cycles -> core granted cycles 0-3; loader granted cycle 4 (wait_cnt=4) with core_stall=1; core granted cycle 5.
- ld_lock burst of 20 writes while core_req=1 -> loader granted 16 cycles; S_RELEASE gives core 1 grant; loader resumes via S_ARB.
- Loader write to addr 0x100 (word 64) and core read at 0x6 -> mem_we=0, ld_err=1; core_err=1, core_rdata=0.
- rst low during S_LOCK with ld_we=1 -> mem_we=0 immediately; state S_ARB; no rvalid pulse after rst release.
- With DMEM_ARB_STATS_EN: 10 conflict cycles -> stat_conflict=10, stat_core_gnt=8, stat_ld_gnt=2.
